// File: rtl/vid_mem_responder.sv
// Frame-buffer memory target on the video-controller bus. It grants requests addressed
// to TARGET_ID and either absorbs a write burst or returns a read burst after RD_LATENCY.
//
// state | meaning
// IDLE  | waiting for a request carrying our target ID
// ADDR  | grant cycle; command, length and address are captured
// WDATA | accepting write beats; selin=0 cycles stall
// RWAIT | read latency countdown
// RDATA | streaming read beats back-to-back
module vid_mem_responder #(
  parameter logic [3:0] TARGET_ID  = 4'h1,
  parameter int         DEPTH      = 1024,
  parameter int         RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  reqin,
  input  logic [3:0]  reqtarin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic        selin,
  input  logic [31:0] addrdatain,
  output logic        ackout,
  output logic        selout,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        busy,
  output logic        errout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RSP = 3'b010;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [3:0]    beats_left;
  logic [1:0]    len_q;
  logic [LW-1:0] lat_cnt;

  logic [AW-1:0] addr_idx;
  logic [3:0]    burst_beats;
  logic          wr_en;
  logic          emit;
  logic [AW-1:0] rd_idx;
  logic [3:0]    rd_beats;
  logic [1:0]    rd_len;

  assign addr_idx    = addrdatain[AW+1:2];
  assign burst_beats = 4'd1 << lenin;
  assign busy        = (state != IDLE);
  assign wr_en       = reset && (state == WDATA) && selin;

  // With a latency of one the first beat has to leave straight from ADDR, so the
  // beat source (index, count, length) is taken from the bus in that case.
  always_comb begin
    emit     = 1'b0;
    rd_idx   = idx;
    rd_beats = beats_left;
    rd_len   = len_q;
    case (state)
      ADDR: begin
        emit     = (cmdin == CMD_RD) && (RD_LATENCY == 1);
        rd_idx   = addr_idx;
        rd_beats = burst_beats;
        rd_len   = lenin;
      end
      RWAIT:   emit = (lat_cnt <= LW'(1));
      RDATA:   emit = (beats_left != 4'd0);
      default: emit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= addrdatain;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ackout      <= 1'b0;
      selout      <= 1'b0;
      cmdout      <= 3'b000;
      lenout      <= 2'b00;
      addrdataout <= 32'h0;
      errout      <= 1'b0;
      idx         <= '0;
      beats_left  <= 4'd0;
      len_q       <= 2'b00;
      lat_cnt     <= '0;
    end else begin
      ackout      <= 1'b0;
      selout      <= 1'b0;
      cmdout      <= 3'b000;
      lenout      <= 2'b00;
      addrdataout <= 32'h0;
      case (state)
        IDLE: begin
          if (reqin != 2'b00 && reqtarin == TARGET_ID) begin
            ackout <= 1'b1;
            state  <= ADDR;
          end
        end
        ADDR: begin
          idx        <= addr_idx;
          len_q      <= lenin;
          beats_left <= burst_beats;
          lat_cnt    <= LW'(RD_LATENCY - 1);
          if (cmdin == CMD_WR) begin
            state <= WDATA;
          end else if (cmdin == CMD_RD) begin
            if (RD_LATENCY == 1) state <= RDATA;
            else                 state <= RWAIT;
          end else begin
            errout <= 1'b1;
            state  <= IDLE;
          end
        end
        WDATA: begin
          if (selin) begin
            idx        <= idx + 1'b1;
            beats_left <= beats_left - 4'd1;
            if (beats_left == 4'd1) state <= IDLE;
          end
        end
        RWAIT: begin
          if (lat_cnt <= LW'(1)) state <= RDATA;
          else                   lat_cnt <= lat_cnt - 1'b1;
        end
        RDATA: begin
          if (beats_left == 4'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (emit) begin
        selout      <= 1'b1;
        cmdout      <= CMD_RSP;
        lenout      <= rd_len;
        addrdataout <= mem[rd_idx];
        idx         <= rd_idx + 1'b1;
        beats_left  <= rd_beats - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_vid_mem_responder.sv
// Bench for vid_mem_responder: table of write/read bursts against a word model, read
// beats checked through an expectation queue, plus hand sequences for corner cases.
module tb_vid_mem_responder;

  localparam logic [3:0] TID   = 4'h1;
  localparam int         DEPTH = 1024;
  localparam int         AW    = 10;
  localparam int         LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  reqin;
  logic [3:0]  reqtarin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic        selin;
  logic [31:0] addrdatain;
  logic        ackout, selout, busy, errout;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;

  vid_mem_responder #(.TARGET_ID(TID), .DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .reqin(reqin), .reqtarin(reqtarin), .cmdin(cmdin),
    .lenin(lenin), .selin(selin), .addrdatain(addrdatain), .ackout(ackout),
    .selout(selout), .cmdout(cmdout), .lenout(lenout), .addrdataout(addrdataout),
    .busy(busy), .errout(errout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  lenc;
    logic [31:0] base;
    int          stall;
    logic [31:0] exp_first;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  l;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  exp_t        q[$];
  logic        ack_prev = 1'b0;
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (selout) begin
      if (q.size() == 0) begin
        chk("rd_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rd_data", addrdataout, e.d);
        chk("rd_cmd", {29'd0, cmdout}, 32'd2);
        chk("rd_len", {30'd0, lenout}, {30'd0, e.l});
      end
    end else begin
      chk("idle_outputs_zero", {27'd0, cmdout, lenout} | addrdataout, 32'd0);
    end
    if (ackout) chk("ack_consecutive", {31'd0, ack_prev}, 32'd0);
    ack_prev = ackout;
  end

  task automatic request();
    bit got = 0;
    reqin    = 2'b01;
    reqtarin = TID;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ackout) begin
        got = 1;
        break;
      end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    reqin = 2'b00;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] lenc,
                          input logic [31:0] base, input int stall);
    int n = 1 << lenc;
    int w = int'(addr[AW+1:2]);
    request();
    cmdin = 3'b100; lenin = lenc; addrdatain = addr;
    @(posedge clk); #1;
    cmdin = 3'b000;
    for (int b = 0; b < n; b++) begin
      selin = 1'b1;
      addrdatain = base + b;
      model[(w + b) % DEPTH] = base + b;
      @(posedge clk); #1;
      selin = 1'b0;
      if (b != n - 1) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("wr_stall_busy", {31'd0, busy}, 32'd1);
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    chk("wr_done_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic push_read(input logic [31:0] addr, input logic [1:0] lenc);
    int w = int'(addr[AW+1:2]);
    for (int b = 0; b < (1 << lenc); b++) q.push_back('{model[(w + b) % DEPTH], lenc});
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] lenc,
                         input logic [31:0] exp_first);
    int lat = 0;
    int cnt = 0;
    logic [31:0] first = 32'h0;
    request();
    cmdin = 3'b001; lenin = lenc; addrdatain = addr;
    push_read(addr, lenc);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      cmdin = 3'b000;
      if (selout) begin
        lat = k;
        first = addrdataout;
        break;
      end
    end
    chk("rd_latency", lat, LAT);
    chk("rd_first_data", first, exp_first);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!selout) break;
      cnt++;
    end
    chk("rd_beat_count", cnt, 1 << lenc);
    chk("rd_done_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{1'b1, 32'h100, 2'b10, 32'hA0, 0, 32'h0};
    vecs[1] = '{1'b0, 32'h100, 2'b10, 32'h0,  0, 32'hA0};
    vecs[2] = '{1'b1, 32'h000, 2'b00, 32'h55, 0, 32'h0};
    vecs[3] = '{1'b0, 32'h000, 2'b00, 32'h0,  0, 32'h55};
    vecs[4] = '{1'b1, 32'h200, 2'b01, 32'hB0, 3, 32'h0};
    vecs[5] = '{1'b0, 32'h200, 2'b01, 32'h0,  0, 32'hB0};
    vecs[6] = '{1'b1, (DEPTH - 2) * 4, 2'b11, 32'hC0, 0, 32'h0};
    vecs[7] = '{1'b0, (DEPTH - 2) * 4, 2'b11, 32'h0,  0, 32'hC0};
    vecs[8] = '{1'b0, 32'h000, 2'b10, 32'h0,  0, 32'hC2};
    vecs[9] = '{1'b0, 32'h103, 2'b01, 32'h0,  0, 32'hA0};

    reset = 1'b0; reqin = 2'b00; reqtarin = 4'h0; cmdin = 3'b000;
    lenin = 2'b00; selin = 1'b0; addrdatain = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {28'd0, ackout, selout, busy, errout}, 32'd0);
    chk("reset_data", {27'd0, cmdout, lenout} | addrdataout, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].lenc, vecs[i].base, vecs[i].stall);
      else            do_read(vecs[i].addr, vecs[i].lenc, vecs[i].exp_first);
    end

    // Foreign target ID: never granted, never busy.
    reqin = 2'b01; reqtarin = TID + 4'h1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("foreign_id_idle", {30'd0, ackout, busy}, 32'd0);
    end
    reqin = 2'b00;

    request();
    cmdin = 3'b111; lenin = 2'b00; addrdatain = 32'h0;
    @(posedge clk); #1;
    cmdin = 3'b000;
    @(negedge clk);
    chk("err_set", {30'd0, errout, busy}, 32'd2);
    do_write(32'h300, 2'b00, 32'hE0, 0);
    do_read(32'h300, 2'b00, 32'hE0);
    chk("err_sticky", {31'd0, errout}, 32'd1);

    // Reset during the third beat of an 8-beat read.
    request();
    cmdin = 3'b001; lenin = 2'b11; addrdatain = 32'h100;
    push_read(32'h100, 2'b11);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      cmdin = 3'b000;
      if (selout) cnt++;
      if (cnt == 3) break;
    end
    chk("abort_reached_beat3", cnt, 3);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", {28'd0, ackout, selout, busy, errout}, 32'd0);
    chk("abort_data", {27'd0, cmdout, lenout} | addrdataout, 32'd0);
    q.delete();
    reset = 1'b1;
    do_read(32'h100, 2'b00, 32'hA0);
    chk("abort_mem_kept", {31'd0, errout}, 32'd0);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1);
  end

endmodule
